// File: rtl/mem_word_responder.sv
// -----------------------------------------------------------------------------
// mem_word_responder
//
// Data-memory responder for the accumulator CPU's execute/memory stage.
// It serves 16-bit little-endian word loads and stores from a byte-addressed,
// single-port storage array that this block owns. Each word is two byte
// accesses: the low byte is at addr and the high byte is at addr+1. The second
// address wraps modulo MEM_SIZE.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   halt_program 1 = accept no new request; an in-flight request still completes
//   req_valid    request present
//   req_ready    request can be accepted (IDLE, not halted, not in reset)
//   req_we       1 = store word, 0 = load word
//   req_addr     byte address of the low byte
//   req_wdata    store data
//   rsp_valid    response present
//   rsp_ready    initiator accepts the response
//   rsp_rdata    load: {mem[a+1], mem[a]}; store: echo of the written word
//   rsp_we       opcode of the request being answered
//   busy         1 in any state other than IDLE
// -----------------------------------------------------------------------------
module mem_word_responder #(
    parameter int MEM_SIZE = 65536,
    parameter int AW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt_program,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [15:0]   rsp_rdata,
    output logic          rsp_we,
    output logic          busy
);

    localparam int IW = $clog2(MEM_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    // The storage array is never reset, so its contents survive a reset.
    logic [7:0]    mem [MEM_SIZE];

    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [15:0]   wdata_q;
    logic [7:0]    lo_byte;

    logic [IW-1:0] idx_lo;
    logic [IW-1:0] idx_hi;
    logic          accept;

    // The high-byte index is IW bits wide, so it wraps naturally at the top.
    assign idx_lo = addr_q[IW-1:0];
    assign idx_hi = idx_lo + 1'b1;

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        state_nxt = state;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = rst && !halt_program;
                if (req_valid && req_ready) state_nxt = LO;
            end
            LO:   state_nxt = HI;
            HI:   state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && req_valid && req_ready;

    // Control state and the response registers. The response registers load
    // only on the HI -> RESP transition, so they hold their value while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rsp_rdata <= 16'h0000;
            rsp_we    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == HI) begin
                rsp_we    <= we_q;
                rsp_rdata <= we_q ? wdata_q : {mem[idx_hi], lo_byte};
            end
        end
    end

    // Request capture and the byte accesses. A reset forces the FSM to IDLE
    // at once, so a store interrupted in HI keeps its low byte and never
    // writes its high byte.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
        end
        if (state == LO) begin
            if (we_q) mem[idx_lo] <= wdata_q[7:0];
            else      lo_byte     <= mem[idx_lo];
        end
        if (state == HI && we_q) begin
            mem[idx_hi] <= wdata_q[15:8];
        end
    end

endmodule

// File: tb/tb_mem_word_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_word_responder
//
// Directed bench for mem_word_responder. It drives inputs and samples outputs
// on the falling clock edge. Each comparison is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_mem_word_responder;

    logic        clk;
    logic        rst;
    logic        halt_program;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_we;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_word_responder #(
        .MEM_SIZE (65536),
        .AW       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .halt_program (halt_program),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_we       (rsp_we),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction. The caller supplies the expected response
    // word, a mask for the bits that are known, the number of extra RESP
    // cycles with rsp_ready low, and whether halt rises while the FSM is in LO.
    task automatic txn(input string tag, input logic we, input logic [15:0] addr,
                       input logic [15:0] wd, input int hold, input logic halt_mid,
                       input logic [15:0] exp, input logic [15:0] mask);
        @(negedge clk);
        chk({tag, "_ready_idle"}, {15'd0, req_ready}, 16'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);                          // cycle N+1 (LO)
        req_we       = ~we;                      // junk that must be ignored
        req_addr     = addr ^ 16'h5A5A;
        req_wdata    = ~wd;
        halt_program = halt_mid;
        chk({tag, "_busy_n1"},  {15'd0, busy},      16'd1);
        chk({tag, "_ready_n1"}, {15'd0, req_ready}, 16'd0);
        chk({tag, "_valid_n1"}, {15'd0, rsp_valid}, 16'd0);
        @(negedge clk);                          // cycle N+2 (HI)
        chk({tag, "_busy_n2"},  {15'd0, busy},      16'd1);
        chk({tag, "_valid_n2"}, {15'd0, rsp_valid}, 16'd0);
        @(negedge clk);                          // cycle N+3 (RESP)
        chk({tag, "_valid_n3"}, {15'd0, rsp_valid}, 16'd1);
        chk({tag, "_busy_n3"},  {15'd0, busy},      16'd1);
        chk({tag, "_ready_n3"}, {15'd0, req_ready}, 16'd0);
        chk({tag, "_we"},       {15'd0, rsp_we},    {15'd0, we});
        chk({tag, "_rdata"},    rsp_rdata & mask,   exp & mask);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {15'd0, rsp_valid}, 16'd1);
            chk({tag, "_hold_ready"}, {15'd0, req_ready}, 16'd0);
            chk({tag, "_hold_rdata"}, rsp_rdata & mask,   exp & mask);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);                          // back in IDLE
        chk({tag, "_valid_done"}, {15'd0, rsp_valid}, 16'd0);
        chk({tag, "_busy_done"},  {15'd0, busy},      16'd0);
        chk({tag, "_rdata_held"}, rsp_rdata & mask,   exp & mask);
        rsp_ready    = 1'b0;
        halt_program = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        halt_program = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 16'h0000;
        req_wdata    = 16'h0000;
        rsp_ready    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {15'd0, req_ready}, 16'd0);
        chk("rst_busy",      {15'd0, busy},      16'd0);
        chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        chk("rst_rsp_rdata", rsp_rdata,          16'h0000);
        chk("rst_rsp_we",    {15'd0, rsp_we},    16'd0);
        rst = 1'b1;

        // Store then load a word
        txn("st_beef", 1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, 16'hBEEF, 16'hFFFF);
        txn("ld_beef", 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 16'hBEEF, 16'hFFFF);

        // Word at the top of memory wraps to address 0
        txn("st_wrap",  1'b1, 16'hFFFF, 16'h1234, 0, 1'b0, 16'h1234, 16'hFFFF);
        txn("ld_wrap",  1'b0, 16'hFFFF, 16'h0000, 0, 1'b0, 16'h1234, 16'hFFFF);
        txn("ld_zero",  1'b0, 16'h0000, 16'h0000, 0, 1'b0, 16'h0012, 16'h00FF);
        txn("ld_0x10b", 1'b0, 16'h0011, 16'h0000, 0, 1'b0, 16'h00BE, 16'h00FF);

        // Response backpressure for three cycles
        txn("ld_hold", 1'b0, 16'h0010, 16'h0000, 3, 1'b0, 16'hBEEF, 16'hFFFF);

        // Halt in IDLE blocks acceptance and leaves memory alone
        @(negedge clk);
        halt_program = 1'b1;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 16'h0010;
        req_wdata    = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_req_ready", {15'd0, req_ready}, 16'd0);
            chk("halt_busy",      {15'd0, busy},      16'd0);
        end
        req_valid    = 1'b0;
        halt_program = 1'b0;
        txn("ld_after_halt", 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 16'hBEEF, 16'hFFFF);

        // Halt rising during LO does not stop the request
        txn("st_halt_mid", 1'b1, 16'h0030, 16'h0F0F, 0, 1'b1, 16'h0F0F, 16'hFFFF);
        txn("ld_halt_mid", 1'b0, 16'h0030, 16'h0000, 0, 1'b0, 16'h0F0F, 16'hFFFF);

        // Reset while in HI keeps the low byte and produces no response
        txn("st_pre", 1'b1, 16'h0020, 16'h1111, 0, 1'b0, 16'h1111, 16'hFFFF);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hAA55;
        @(negedge clk);                          // LO
        req_valid = 1'b0;
        chk("rhi_busy_lo", {15'd0, busy}, 16'd1);
        @(negedge clk);                          // HI
        rst = 1'b0;
        #1;
        chk("rhi_busy",      {15'd0, busy},      16'd0);
        chk("rhi_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        chk("rhi_req_ready", {15'd0, req_ready}, 16'd0);
        chk("rhi_rsp_rdata", rsp_rdata,          16'h0000);
        @(negedge clk);
        chk("rhi_valid_lat", {15'd0, rsp_valid}, 16'd0);
        rst = 1'b1;
        #1;
        chk("rhi_ready_rel", {15'd0, req_ready}, 16'd1);
        txn("ld_partial", 1'b0, 16'h0020, 16'h0000, 0, 1'b0, 16'h1155, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
